// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised RAM and its clear sequencer.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  // Number of byte-enable bits for a given word width.
  function automatic int wbe_width(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_param_if.sv
// User-side port bundle of ram_param: write/read channels, clear request and status.
interface ram_param_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int WBE_W = wbe_width(DATA_WIDTH);

  logic                  ena;
  logic                  wena;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WBE_W-1:0]      wbe;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rvalid;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output ena, wena, waddr, wbe, data_in, rd_en, raddr, clr_req,
    input  data_out, rvalid, busy
  );

  modport slave (
    input  ena, wena, waddr, wbe, data_in, rd_en, raddr, clr_req,
    output data_out, rvalid, busy
  );

endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1 after reset or on request.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  // Terminal check at DEPTH-1 keeps clr_addr from ever wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  // State and sweep address registers; reset starts a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= addr_nxt;
    end
  end

  // Next state: requests only start a sweep from IDLE, never extend one.
  always_comb begin
    state_nxt = state;
    addr_nxt  = clr_addr;
    unique case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          addr_nxt  = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
        else                       addr_nxt  = clr_addr + 1'b1;
      end
    endcase
  end

  assign busy   = (state == ST_CLEAR);
  assign clr_we = busy;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-clock RAM: byte write enables, registered read with
// rvalid strobe, write-first bypass, and a hardware clear sweep.
// Optional macro RAM_OUT_REG_EN adds a second output register (latency 2).
module ram_param
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic         clk,
  input logic         rst_n,
  ram_param_if.slave  bus
);

  localparam int NB = wbe_width(DATA_WIDTH);
`ifdef RAM_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [DATA_WIDTH-1:0]         mem [DEPTH];
  logic                          clr_we, busy;
  logic [ADDR_WIDTH-1:0]         clr_addr;
  logic                          user_we, rd_fire, hit;
  logic [NB-1:0][BYTE_W-1:0]     rword, rdata, wword;
  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

  ram_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (bus.clr_req),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  // A clear request in IDLE wins over a same-cycle user write.
  assign user_we = bus.ena & bus.wena & ~busy & ~bus.clr_req
                 & (32'(bus.waddr) < DEPTH);
  assign rd_fire = bus.ena & bus.rd_en & ~busy;
  assign hit     = user_we & (bus.waddr == bus.raddr);
  assign wword   = bus.data_in;

  // Array write port: sweep has the port while busy, else byte-masked user write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (user_we) begin
      for (int k = 0; k < NB; k++)
        if (bus.wbe[k]) mem[bus.waddr][k*BYTE_W +: BYTE_W] <= bus.data_in[k*BYTE_W +: BYTE_W];
    end
  end

  // Read word with per-byte write-first bypass; out-of-range reads give 0.
  always_comb begin
    rword = '0;
    if (32'(bus.raddr) < DEPTH) rword = mem[bus.raddr];
    rdata = rword;
    for (int k = 0; k < NB; k++)
      if (hit && bus.wbe[k]) rdata[k] = wword[k];
  end

  // Output pipeline: stages load only when a read is in flight, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      if (rd_fire) dat_pipe[1] <= rdata;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign bus.data_out = dat_pipe[STAGES];
  assign bus.rvalid   = vld_pipe[STAGES];
  assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: table-driven vectors, directed clear/reset
// sequences, and random traffic against a word-level reference model.
module tb_ram_param;

  localparam int          DW    = 32;
  localparam int          AW    = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] INIT  = 32'hDEADBEEF;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_VALUE(INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: memory contents, remaining sweep cycles, pending reads.
  logic [31:0] mdl_mem [DEPTH];
  int          busy_left = DEPTH;
  logic [31:0] last_dout = '0;
  typedef struct { logic [31:0] d; int due; } rd_t;
  rd_t exp_q[$];

  typedef struct {
    logic        ena, wena;
    logic [4:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] din;
    logic        rd_en;
    logic [4:0]  raddr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic ena, input logic wena, input logic [4:0] waddr,
                      input logic [3:0] wbe, input logic [31:0] din, input logic rd_en,
                      input logic [4:0] raddr, input logic clr_req);
    logic [31:0] w;
    rd_t r;
    bus.ena = ena; bus.wena = wena; bus.waddr = waddr; bus.wbe = wbe;
    bus.data_in = din; bus.rd_en = rd_en; bus.raddr = raddr; bus.clr_req = clr_req;
    if (busy_left > 0) begin
      mdl_mem[DEPTH - busy_left] = INIT;
      busy_left--;
    end else begin
      if (clr_req) busy_left = DEPTH;
      else if (ena && wena) begin
        w = mdl_mem[waddr];
        for (int k = 0; k < 4; k++) if (wbe[k]) w[8*k +: 8] = din[8*k +: 8];
        mdl_mem[waddr] = w;
      end
      if (ena && rd_en) begin
        r.d = mdl_mem[raddr];
        r.due = cyc + LAT;
        exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      last_dout = exp_q[0].d;
      void'(exp_q.pop_front());
      check("rvalid", 32'(bus.rvalid), 32'd1);
    end else begin
      check("rvalid", 32'(bus.rvalid), 32'd0);
    end
    check("data_out", bus.data_out, last_dout);
    check("busy", 32'(bus.busy), 32'(busy_left > 0));
  endtask

  task automatic idle(); step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0); endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(i), 1'b0);
    repeat (LAT) idle();
  endtask

  task automatic do_reset();
    bus.ena = 1'b0; bus.wena = 1'b0; bus.rd_en = 1'b0; bus.clr_req = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    busy_left = DEPTH;
    last_dout = '0;
  endtask

  // Count cycles until busy drops (bounded); optionally hold clr_req meanwhile.
  task automatic measure_busy(input string name, input logic hold_req);
    int n = 0;
    while (bus.busy && n < 100) begin
      step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, hold_req);
      n++;
    end
    check(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ena = 1'b0; bus.wena = 1'b0; bus.waddr = '0; bus.wbe = '0; bus.data_in = '0;
    bus.rd_en = 1'b0; bus.raddr = '0; bus.clr_req = 1'b0;
    @(posedge clk); #1;

    // Power-up sweep and INIT readback.
    do_reset();
    measure_busy("reset_busy_len", 1'b0);
    read_all();

    // Full-word fill with descending pattern, back-to-back readback.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 5'(i), 4'hF, 32'hFFFFFFFF - 32'(i), 1'b0, 5'd0, 1'b0);
    read_all();

    // Byte merge, write-first bypass, wbe=0, partial lanes.
    tbl[0] = '{1'b1, 1'b1, 5'd5,  4'hF,    32'h11223344, 1'b0, 5'd0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 5'd5,  4'b0101, 32'hAABBCCDD, 1'b0, 5'd0,  1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 5'd0,  4'h0,    32'h0,        1'b1, 5'd5,  1'b1, 32'h11BB33DD};
    tbl[3] = '{1'b1, 1'b1, 5'd7,  4'hF,    32'h12345678, 1'b0, 5'd0,  1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 5'd7,  4'b0011, 32'h0000ABCD, 1'b1, 5'd7,  1'b1, 32'h1234ABCD};
    tbl[5] = '{1'b1, 1'b1, 5'd5,  4'h0,    32'h00000000, 1'b1, 5'd5,  1'b1, 32'h11BB33DD};
    tbl[6] = '{1'b1, 1'b0, 5'd0,  4'h0,    32'h0,        1'b1, 5'd7,  1'b1, 32'h1234ABCD};
    tbl[7] = '{1'b1, 1'b1, 5'd31, 4'b1010, 32'h5A5A5A5A, 1'b0, 5'd0,  1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 5'd0,  4'h0,    32'h0,        1'b1, 5'd31, 1'b1, 32'h5AFF5AE0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].ena, tbl[i].wena, tbl[i].waddr, tbl[i].wbe, tbl[i].din,
           tbl[i].rd_en, tbl[i].raddr, 1'b0);
      if (tbl[i].chk) begin
        repeat (LAT - 1) idle();
        check("tbl_data", bus.data_out, tbl[i].exp);
        check("tbl_rvalid", 32'(bus.rvalid), 32'd1);
      end
    end

    // ena=0 gating with write and read requested.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 5'($urandom_range(0, 31)), 4'hF, 32'h0, 1'b1, 5'($urandom_range(0, 31)), 1'b0);
    read_all();

    // Clear request in IDLE drops a same-cycle write; request held while busy is ignored.
    step(1'b1, 1'b1, 5'd3, 4'hF, 32'h12345678, 1'b0, 5'd0, 1'b1);
    measure_busy("clr_busy_len", 1'b1);
    read_all();

    // Reset mid-sweep at clr_addr=10 restarts a full sweep.
    do_reset();
    repeat (10) idle();
    do_reset();
    measure_busy("rst_mid_busy_len", 1'b0);
    read_all();

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 79) == 0));
    for (int i = 0; i < 40 && busy_left > 0; i++) idle();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-clock RAM; next generation of the 32x32 `ram` (clk/ena/wena/addr/data_in/data_out).
- Adds separate read/write addresses, byte write enables, a read-valid strobe, and a hardware clear sequencer.
- Clear sequencer fills the array with INIT_VALUE after reset or on request.
- Sits as general data/instruction storage beside the CPU datapath blocks.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8
ADDR_WIDTH, 5, address width
DEPTH, 32, number of words; must be <= 2**ADDR_WIDTH
INIT_VALUE, 0, word written to every address by the clear sweep (DATA_WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; 0 blocks all reads and writes
wena  in  1  write enable
waddr  in  ADDR_WIDTH  write address
wbe  in  DATA_WIDTH/8  byte write enables; bit k covers data bits [8k+7:8k]
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request
raddr  in  ADDR_WIDTH  read address
data_out  out  DATA_WIDTH  read data, registered
rvalid  out  1  one-cycle strobe; data_out is new this cycle
clr_req  in  1  request a clear sweep
busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst_n=0, async):
  - data_out=0, rvalid=0, busy=1.
  - FSM enters CLEAR with clr_addr=0.
  - The array itself is not reset.
- FSM state CLEAR:
  - Each cycle writes INIT_VALUE to clr_addr, then clr_addr increments.
  - After the edge that writes DEPTH-1, go to IDLE; busy=0 from that edge.
  - Sweep takes exactly DEPTH cycles after rst_n rises.
- FSM state IDLE:
  - clr_req=1 at an edge: go to CLEAR (busy=1 after that edge), clr_addr=0.
  - clr_req has priority over a user write in the same cycle; that write is dropped.
- While busy=1:
  - User ena/wena/rd_en are ignored; rvalid=0; data_out holds.
  - clr_req is ignored; no restart.
- Write: at an edge with ena & wena & !busy & (waddr<DEPTH):
  - Bytes with wbe[k]=1 take data_in; the other bytes keep their old value.
  - wbe=0 means no change.
- Read: at edge N with ena & rd_en & !busy:
  - data_out is updated after edge N; rvalid=1 for exactly one cycle (latency 1).
  - raddr>=DEPTH returns 0.
  - Without a read, data_out holds its last value and rvalid=0.
- Read-during-write to the same address is write-first, per byte: enabled bytes show data_in, the rest show old data.
- ena=0: no write, no read, rvalid=0, data_out holds. The clear sweep still runs (not gated by ena).
- Reset mid-sweep: sweep restarts from address 0 after release.
- Address arithmetic: clr_addr is ADDR_WIDTH bits; it never wraps, because the terminal check is at DEPTH-1.

Optional Feature:
RAM_OUT_REG_EN:
- Defined: adds an output pipeline register. Read latency is 2; rvalid is delayed to match; write-first bypass is taken at the first stage. Both stages reset to 0, and both hold when no read is in flight.
- Undefined: latency 1, exactly as above.

Decomposition:
- Package ram_pkg:
  - clear FSM state typedef (ST_IDLE, ST_CLEAR)
  - BYTE_W=8 constant
  - function computing wbe width from DATA_WIDTH
- One sub-module, ram_clear_ctrl:
  - Owns the FSM, clr_addr and busy.
  - Outputs clr_we/clr_addr to the array write mux.

Test Plan:
- Reset release, INIT_VALUE=32'hDEADBEEF: busy high exactly 32 cycles, then reads of addr 0..31 all return 32'hDEADBEEF with rvalid one cycle after rd_en.
- Write 32'hFFFFFFFF-i to addr i for i=0..31 with wbe=4'hF, then read 0..31: returns 32'hFFFFFFFF..32'hFFFFFFE0 in order, rvalid each cycle for back-to-back reads.
- Byte merge: write 32'h11223344 to addr 5 with wbe=4'hF, then 32'hAABBCCDD with wbe=4'b0101; read addr 5 gives 32'h11BB33DD.
- Read-during-write: addr 7 holds 32'h12345678; same-cycle write 32'h0000ABCD with wbe=4'b0011 and read of addr 7 gives 32'h1234ABCD.
- Enable gating: ena=0 for 10 cycles with wena=1, rd_en=1, data_in=0: memory unchanged on later readback, rvalid=0, data_out holds.
- Clear control:
  - clr_req in IDLE: busy for 32 cycles, then memory reads INIT_VALUE.
  - clr_req while busy: no extension.
  - rst_n pulsed at clr_addr=10: sweep restarts and busy lasts a full 32 cycles.
  - With RAM_OUT_REG_EN, read latency is 2.
